// File: rtl/utopia_rx_cell_assembler.sv
// rtl/utopia_rx_cell_assembler.sv - UTOPIA receive byte stream to 53-byte ATM cell assembler with HEC check
module utopia_rx_cell_assembler #(
    parameter int IfWidth   = 8,
    parameter int CellBytes = 53
) (
    input  logic                   clk_in,
    input  logic                   reset,
    input  logic [IfWidth-1:0]     data,
    input  logic                   soc,
    input  logic                   clav,
    output logic                   en,
    output logic [CellBytes*8-1:0] ATMcell,
    output logic                   valid,
    input  logic                   ready,
    output logic                   hec_err,
    output logic                   runt_err,
    output logic [15:0]            cell_count
);

    generate
        if (IfWidth != 8) begin : g_bad_width
            $error("utopia_rx_cell_assembler: only IfWidth == 8 is supported");
        end
    endgenerate

    localparam int              IdxW    = $clog2(CellBytes);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(CellBytes - 1);
    localparam logic [IdxW-1:0] HecIdx  = IdxW'(4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IdxW-1:0] byte_idx;
    logic [7:0]      crc;
    logic [7:0]      cell_mem [CellBytes];
    logic            xfer;

    // CRC-8, x^8+x^2+x+1, one byte MSB first
    function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic [7:0] d);
        logic [7:0] c;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            if (c[7] ^ d[i]) begin
                c = {c[6:0], 1'b0} ^ 8'h07;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

    assign xfer = en && clav;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // soc always restarts a cell, so it wins over reaching the last byte
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (xfer && soc) state_next = RECV;
            RECV: if (xfer && !soc && byte_idx == LastIdx) state_next = HOLD;
            HOLD: if (ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        en    = (state != HOLD) && !reset;
        valid = (state == HOLD);
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            byte_idx <= '0;
            hec_err  <= 1'b0;
            runt_err <= 1'b0;
            crc      <= 8'h00;
            for (int i = 0; i < CellBytes; i++) begin
                cell_mem[i] <= 8'h00;
            end
        end else begin
            runt_err <= 1'b0;
            if (xfer && soc) begin
                cell_mem[0] <= data;
                byte_idx    <= IdxW'(1);
                crc         <= crc8_step(8'h00, data);
                hec_err     <= 1'b0;
                runt_err    <= (state == RECV);
            end else if (xfer && state == RECV) begin
                cell_mem[byte_idx] <= data;
                byte_idx           <= (byte_idx == LastIdx) ? '0 : byte_idx + 1'b1;
                if (byte_idx < HecIdx) begin
                    crc <= crc8_step(crc, data);
                end
                if (byte_idx == HecIdx) begin
                    hec_err <= (data != (crc ^ 8'h55));
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            cell_count <= 16'h0000;
        end else if (valid && ready && !hec_err && cell_count != 16'hFFFF) begin
            cell_count <= cell_count + 16'd1;
        end
    end

    genvar g;
    generate
        for (g = 0; g < CellBytes; g++) begin : g_pack
            assign ATMcell[(CellBytes-1-g)*8 +: 8] = cell_mem[g];
        end
    endgenerate

endmodule

// File: doc/utopia_rx_cell_assembler.md
Name: utopia_rx_cell_assembler

Overview:
Receive-side core stage that consumes the 8-bit UTOPIA byte stream from a PHY port and assembles complete 53-byte ATM cells. Drives the UTOPIA receive enable and checks header HEC. Presents each finished cell as one wide word with a valid/ready handshake to the downstream cell processor (header rewrite / forwarding). Single cell buffer; back-pressure from downstream throttles the PHY through en.

Parameters:
IfWidth, 8, UTOPIA data width in bits; only 8 is supported; any other value is an elaboration error.
CellBytes, 53, bytes per ATM cell (5 header + 48 payload).

Ports:
clk_in  input  1  receive clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
data  input  8  UTOPIA receive byte.
soc  input  1  start-of-cell; high with byte 0 of a cell.
clav  input  1  PHY cell-available; a byte is present when high.
en  output  1  receive enable, active-high; PHY may only transfer while high.
ATMcell  output  424  assembled cell; byte 0 in [423:416], byte 52 in [7:0].
valid  output  1  ATMcell holds a complete cell.
ready  input  1  downstream accepts the cell when valid && ready.
hec_err  output  1  header HEC mismatch for the presented cell; qualified by valid.
runt_err  output  1  one-cycle pulse: a partial cell was discarded.
cell_count  output  16  cells delivered with good HEC; saturates at 16'hFFFF.

Behaviour:
- Byte transfer: occurs on a rising edge where en==1 && clav==1. No transfer when clav==0: the byte counter holds (stall), and data/soc are ignored.
- en = (state != HOLD) && !reset; combinational from state.
- FSM states:
  - IDLE: waiting for a transfer with soc==1. Transfers with soc==0 are discarded silently. A soc transfer stores byte 0, sets byte_idx=1, and moves to RECV.
  - RECV: each transfer stores data at byte_idx, then byte_idx++. Storing byte 52 moves to HOLD.
    - A transfer with soc==1 in RECV aborts the current cell. That byte becomes the new byte 0, byte_idx=1, and runt_err pulses for one cycle.
  - HOLD: valid=1, en=0. On valid && ready, move to IDLE; valid falls and en rises in the next cycle.
- Latency: valid is high in the cycle after the edge that stores byte 52. A cell sent back-to-back occupies 53 + 1 + handshake cycles minimum. There is no overlap of receive and hold.
- ATMcell is stable for the whole of HOLD. Its contents are don't-care outside HOLD.
- HEC:
  - CRC-8, polynomial x^8+x^2+x+1, init 0x00.
  - Computed serially over bytes 0–3 as they arrive, then XORed with 0x55.
  - Compared with byte 4 when byte 4 is stored; the registered mismatch becomes hec_err.
  - hec_err holds through HOLD and is cleared on the next soc byte.
  - Cells with hec_err=1 are still delivered; cell_count does not increment for them.
- cell_count increments by 1 on each handshake with hec_err==0, and saturates at 16'hFFFF (no wrap).
- Reset values: state=IDLE, byte_idx=0, valid=0, hec_err=0, runt_err=0, cell_count=0, ATMcell=0. en=0 while reset is high.
- Reset mid-cell: the partial cell is dropped with no runt_err pulse. Reset in HOLD drops the held cell with no handshake.
- soc and stall on the same edge: clav==0 takes priority, so nothing is transferred.
- ready is ignored outside HOLD.

Test Plan:
1. Reset, then one cell: header 00 00 00 00 55, payload 0x01..0x30, clav=1 continuous. Expect valid one cycle after byte 52; ATMcell[423:384]=00000000_55, [7:0]=0x30; hec_err=0; cell_count=1 after handshake.
2. Header 00 00 00 01 52: hec_err=0. Same header with byte 4 = 0x55: hec_err=1, cell still delivered, cell_count unchanged.
3. Deassert clav for 3 cycles after byte 20 of a cell. Expect byte_idx to hold, and the cell to complete with contents identical to the unstalled cell; valid is delayed by exactly 3 cycles.
4. Assert soc at byte 30 of a cell. Expect runt_err to pulse once, the first 30 bytes to be discarded, and the delivered cell to start with the byte that carried soc.
5. Hold ready=0 for 10 cycles in HOLD. Expect en=0 and ATMcell stable throughout. Raise ready: valid=0 and en=1 on the next cycle. A second cell then received correctly gives cell_count=2.
6. Pulse reset at byte 40, then send a full cell. Expect no valid for the partial cell, no runt_err, and a single correct cell delivered with cell_count=1. Bytes sent before any soc after reset are ignored.
